// File: rtl/tt_bin_clock_set_ctrl.sv
// Binary clock set-input front end: sync, debounce, edge detect and step-pulse FSM.
// Define SET_REPEAT_EN to build the auto-repeat FSM; otherwise each press gives one pulse.
module tt_bin_clock_set_ctrl #(
    parameter int unsigned DB_CYCLES     = 50000,
    parameter int unsigned REPEAT_DELAY  = 500000,
    parameter int unsigned REPEAT_PERIOD = 100000
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic time_set_i,
    input  logic id_switch_i,
    input  logic hour_btn_i,
    input  logic minute_btn_i,
    input  logic seconds_btn_i,
    output logic set_mode_o,
    output logic step_up_o,
    output logic step_hour_o,
    output logic step_minute_o,
    output logic step_seconds_o
);

    localparam int unsigned DbW = $clog2(DB_CYCLES);
    localparam logic [DbW-1:0] DbLast = DbW'(DB_CYCLES - 1);

    if (DB_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : gen_bad_params
        $error("tt_bin_clock_set_ctrl: DB_CYCLES, REPEAT_DELAY, REPEAT_PERIOD must be >= 2");
    end

    typedef enum logic [1:0] {StIdle, StDelay, StRepeat, StHeld} state_e;

    logic [4:0]     raw;
    logic [4:0]     sync1_q, sync2_q;
    logic [1:0]     sync_vld_q;
    logic           set_mode;
    logic [2:0]     btn;
    logic [2:0]     db_q, db_d_q, rise_q, armed_q;
    logic [DbW-1:0] db_cnt_q [3];
    logic [2:0]     pick, sel_q, step_q;
    logic           held;
    state_e         state_q;

    assign raw      = {seconds_btn_i, minute_btn_i, hour_btn_i, id_switch_i, time_set_i};
    assign set_mode = sync2_q[0];
    assign btn      = sync2_q[4:2];

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    // A button is armed only once it has been seen low after reset, so a button held
    // through reset must be released and pressed again before it can step.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync_vld_q <= '0;
            armed_q    <= '0;
            db_q       <= '0;
            db_d_q     <= '0;
            rise_q     <= '0;
            for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
        end else begin
            sync_vld_q <= {sync_vld_q[0], 1'b1};
            if (sync_vld_q[1]) armed_q <= armed_q | ~btn;
            db_d_q <= db_q;
            rise_q <= db_q & ~db_d_q & armed_q;
            for (int i = 0; i < 3; i++) begin
                if (btn[i] == db_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DbLast) begin
                    db_q[i]     <= ~db_q[i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Priority hour > minute > seconds; lower-priority simultaneous rises are dropped.
    always_comb begin
        pick = 3'b000;
        if (rise_q[0])      pick = 3'b001;
        else if (rise_q[1]) pick = 3'b010;
        else if (rise_q[2]) pick = 3'b100;
    end

    assign held = |(db_q & sel_q);

`ifdef SET_REPEAT_EN
    localparam int unsigned RptMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                    : REPEAT_PERIOD;
    localparam int unsigned RptW = $clog2(RptMax);
    localparam logic [RptW-1:0] RptDelayLd  = RptW'(REPEAT_DELAY - 1);
    localparam logic [RptW-1:0] RptPeriodLd = RptW'(REPEAT_PERIOD - 1);

    logic [RptW-1:0] rpt_cnt_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= StIdle;
            sel_q     <= '0;
            step_q    <= '0;
            rpt_cnt_q <= '0;
        end else begin
            step_q <= '0;
            if (!set_mode) begin
                state_q <= StIdle;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (|pick) begin
                            step_q    <= pick;
                            sel_q     <= pick;
                            rpt_cnt_q <= RptDelayLd;
                            state_q   <= StDelay;
                        end
                    end
                    StDelay, StRepeat: begin
                        if (!held) begin
                            state_q <= StIdle;
                        end else if (rpt_cnt_q == '0) begin
                            step_q    <= sel_q;
                            rpt_cnt_q <= RptPeriodLd;
                            state_q   <= StRepeat;
                        end else begin
                            rpt_cnt_q <= rpt_cnt_q - 1'b1;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end
`else
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= StIdle;
            sel_q   <= '0;
            step_q  <= '0;
        end else begin
            step_q <= '0;
            if (!set_mode) begin
                state_q <= StIdle;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (|pick) begin
                            step_q  <= pick;
                            sel_q   <= pick;
                            state_q <= StHeld;
                        end
                    end
                    StHeld: begin
                        if (!held) state_q <= StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end
`endif

    assign set_mode_o     = set_mode;
    assign step_up_o      = sync2_q[1];
    assign step_hour_o    = step_q[0];
    assign step_minute_o  = step_q[1];
    assign step_seconds_o = step_q[2];

endmodule

// File: tb/tb_tt_bin_clock_set_ctrl.sv
// Directed bench for tt_bin_clock_set_ctrl; pulse times are checked against a small
// model of the expected step schedule (repeat schedule only when SET_REPEAT_EN is defined).
module tb_tt_bin_clock_set_ctrl;

    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 3;
`ifdef SET_REPEAT_EN
    localparam bit RptEn = 1'b1;
`else
    localparam bit RptEn = 1'b0;
`endif

    logic clk_i = 1'b0;
    logic rstn_i, time_set_i, id_switch_i, hour_btn_i, minute_btn_i, seconds_btn_i;
    logic set_mode_o, step_up_o, step_hour_o, step_minute_o, step_seconds_o;

    int nvec, nerr, cyc, prev_pulse, t;
    int pt[$];
    int pf[$];
    int pu[$];

    always #5 clk_i = ~clk_i;

    tt_bin_clock_set_ctrl #(
        .DB_CYCLES    (DB),
        .REPEAT_DELAY (RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .time_set_i    (time_set_i),
        .id_switch_i   (id_switch_i),
        .hour_btn_i    (hour_btn_i),
        .minute_btn_i  (minute_btn_i),
        .seconds_btn_i (seconds_btn_i),
        .set_mode_o    (set_mode_o),
        .step_up_o     (step_up_o),
        .step_hour_o   (step_hour_o),
        .step_minute_o (step_minute_o),
        .step_seconds_o(step_seconds_o)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int outs();
        return {27'd0, set_mode_o, step_up_o, step_hour_o, step_minute_o, step_seconds_o};
    endfunction

    task automatic clear_log();
        pt.delete();
        pf.delete();
        pu.delete();
    endtask

    // One clock: sample 1 ns after the rising edge and log any step pulse.
    task automatic tick();
        logic [2:0] s;
        @(posedge clk_i);
        #1;
        cyc++;
        s = {step_seconds_o, step_minute_o, step_hour_o};
        if (s != 3'b000) begin
            check_eq("onehot", $countones(s), 1);
            check_eq("back_to_back", prev_pulse, 0);
            pt.push_back(cyc);
            pf.push_back(s[0] ? 0 : (s[1] ? 1 : 2));
            pu.push_back(int'(step_up_o));
        end
        prev_pulse = (s != 3'b000) ? 1 : 0;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_btn(input int fld, input logic v);
        case (fld)
            0:       hour_btn_i    = v;
            1:       minute_btn_i  = v;
            default: seconds_btn_i = v;
        endcase
    endtask

    // Expected pulses: first at press+DB+4, then +RD, then every RP, while the
    // button (debounced) and set mode are still in effect, i.e. up to cycle 'cut'.
    task automatic check_seq(input string tag, input int t0, input int cut, input int fld,
                             input int up);
        int exp_t[$];
        int tt;
        int gap;
        tt  = t0 + DB + 4;
        gap = RD;
        while (tt <= cut) begin
            exp_t.push_back(tt);
            if (!RptEn) break;
            tt += gap;
            gap = RP;
        end
        check_eq({tag, "_count"}, pt.size(), exp_t.size());
        for (int i = 0; i < exp_t.size() && i < pt.size(); i++) begin
            check_eq($sformatf("%s_time%0d", tag, i), pt[i] - t0, exp_t[i] - t0);
            check_eq($sformatf("%s_field%0d", tag, i), pf[i], fld);
            check_eq($sformatf("%s_dir%0d", tag, i), pu[i], up);
        end
    endtask

    task automatic hold_check(input int fld, input logic up, input int hold, input string tag);
        int t0;
        clear_log();
        id_switch_i = up;
        t0 = cyc;
        set_btn(fld, 1'b1);
        tick_n(hold);
        set_btn(fld, 1'b0);
        tick_n(DB + 12);
        // release is debounced DB+2 cycles after the button drops
        check_seq(tag, t0, t0 + hold + DB + 2, fld, int'(up));
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        cyc = 0;
        prev_pulse = 0;
        rstn_i = 1'b0;
        time_set_i = 1'b1;
        id_switch_i = 1'b1;
        hour_btn_i = 1'b1;
        minute_btn_i = 1'b1;
        seconds_btn_i = 1'b1;

        // Reset with every input high, then release with hour still held.
        tick_n(4);
        check_eq("rst_outputs", outs(), 0);
        minute_btn_i = 1'b0;
        seconds_btn_i = 1'b0;
        rstn_i = 1'b1;
        clear_log();
        tick_n(30);
        check_eq("rst_held_count", pt.size(), 0);
        check_eq("set_mode_sync", int'(set_mode_o), 1);
        check_eq("step_up_sync", int'(step_up_o), 1);
        hour_btn_i = 1'b0;
        tick_n(12);

        hold_check(0, 1'b1, 6, "single");

        // Bounce: toggling never settles, then a clean hold.
        clear_log();
        for (int i = 0; i < 20; i++) begin
            minute_btn_i = (i % 2 == 0);
            tick();
        end
        check_eq("bounce_quiet", pt.size(), 0);
        t = cyc;
        minute_btn_i = 1'b1;
        tick_n(13);
        minute_btn_i = 1'b0;
        tick_n(DB + 12);
        check_seq("bounce", t, t + 13 + DB + 2, 1, 1);

        hold_check(2, 1'b0, 40, "repeat_sec");

        // Simultaneous hour and minute: hour wins.
        clear_log();
        id_switch_i = 1'b1;
        t = cyc;
        hour_btn_i = 1'b1;
        minute_btn_i = 1'b1;
        tick_n(6);
        hour_btn_i = 1'b0;
        minute_btn_i = 1'b0;
        tick_n(DB + 12);
        check_seq("simul", t, t + 6 + DB + 2, 0, 1);

        // Set mode dropped mid-repeat; synced drop lands 2 cycles later.
        clear_log();
        t = cyc;
        seconds_btn_i = 1'b1;
        tick_n(21);
        time_set_i = 1'b0;
        tick();
        check_eq("mode_lag", int'(set_mode_o), 1);
        tick();
        check_eq("mode_off", int'(set_mode_o), 0);
        tick_n(17);
        check_seq("mode_drop", t, t + 21 + 2, 2, 1);
        time_set_i = 1'b1;
        clear_log();
        tick_n(20);
        check_eq("mode_back_held", pt.size(), 0);
        seconds_btn_i = 1'b0;
        tick_n(DB + 12);

        // Asynchronous reset in the middle of a pulse.
        clear_log();
        hour_btn_i = 1'b1;
        tick_n(DB + 4);
        check_eq("pre_rst_pulse", int'(step_hour_o), 1);
        rstn_i = 1'b0;
        #2;
        check_eq("async_rst", outs(), 0);
        tick_n(3);
        rstn_i = 1'b1;
        clear_log();
        tick_n(30);
        check_eq("post_rst_held", pt.size(), 0);
        hour_btn_i = 1'b0;
        tick_n(DB + 12);
        hold_check(0, 1'b1, 40, "rehold_hour");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
